// File: rtl/axil_write_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite write channel between NUM_REQ
// single-write requesters, with a timeout abort for a stalled slave.
module axil_write_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data_i,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_strb_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic [NUM_REQ-1:0]                done_o,
  output logic [1:0]                        resp_o,
  output logic                              timeout_o,
  output logic                              busy_o,
  output logic [ADDR_WIDTH-1:0]             m_aw_addr_o,
  output logic [2:0]                        m_aw_prot_o,
  output logic                              m_aw_valid_o,
  input  logic                              m_aw_ready_i,
  output logic [DATA_WIDTH-1:0]             m_w_data_o,
  output logic [DATA_WIDTH/8-1:0]           m_w_strb_o,
  output logic                              m_w_valid_o,
  input  logic                              m_w_ready_i,
  input  logic [1:0]                        m_b_resp_i,
  input  logic                              m_b_valid_i,
  output logic                              m_b_ready_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W      = $clog2(NUM_REQ);
  localparam int unsigned TMR_W      = $clog2(TIMEOUT_CYCLES);
  // Timer reads 0 in the first ISSUE cycle; aborting when it reaches this
  // value puts the registered abort pulse TIMEOUT_CYCLES-1 cycles after grant.
  localparam logic [TMR_W-1:0] ABORT_AT = TMR_W'(TIMEOUT_CYCLES - 3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [STRB_WIDTH-1:0]   strb_q, strb_d;
  logic                    aw_valid_q, aw_valid_d;
  logic                    w_valid_q, w_valid_d;
  logic                    b_ready_q, b_ready_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic [1:0]              resp_q, resp_d;
  logic                    timeout_q, timeout_d;
  logic [TMR_W-1:0]        timer_q, timer_d;

  logic                    grant_found;
  logic [IDX_W-1:0]        grant_idx;
  logic [IDX_W-1:0]        cand_idx;
  logic [IDX_W-1:0]        gnt_next;
  logic                    abort;
  int unsigned             cand;

  // Round-robin search: first pending requester at or above the pointer, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_found && req_valid_i[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Combinational one-hot accept pulse in the grant cycle; held low during reset.
  always_comb begin
    req_ready_o = '0;
    if (state_q == IDLE && grant_found && !rst_i) req_ready_o[grant_idx] = 1'b1;
  end

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    strb_d     = strb_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    done_d     = '0;
    resp_d     = '0;
    timeout_d  = 1'b0;
    timer_d    = timer_q;
    gnt_next   = (32'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + IDX_W'(1);
    abort      = ((state_q == ISSUE) || (state_q == RESP && !m_b_valid_i)) &&
                 (timer_q == ABORT_AT);

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d    = ISSUE;
          gnt_d      = grant_idx;
          addr_d     = req_addr_i[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          data_d     = req_data_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          strb_d     = req_strb_i[grant_idx*STRB_WIDTH +: STRB_WIDTH];
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          timer_d    = '0;
        end
      end
      ISSUE: begin
        timer_d = timer_q + TMR_W'(1);
        if (aw_valid_q && m_aw_ready_i) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end
        if (w_valid_q && m_w_ready_i) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          state_d   = RESP;
          b_ready_d = 1'b1;
        end
      end
      RESP: begin
        timer_d = timer_q + TMR_W'(1);
        if (m_b_valid_i) begin
          state_d        = IDLE;
          b_ready_d      = 1'b0;
          done_d[gnt_q]  = 1'b1;
          resp_d         = m_b_resp_i;
          ptr_d          = gnt_next;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d       = IDLE;
      aw_valid_d    = 1'b0;
      w_valid_d     = 1'b0;
      b_ready_d     = 1'b0;
      done_d        = '0;
      done_d[gnt_q] = 1'b1;
      resp_d        = 2'b10;
      timeout_d     = 1'b1;
      ptr_d         = gnt_next;
    end
  end

  // State and output registers; reset discards any in-flight transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      done_q     <= '0;
      resp_q     <= '0;
      timeout_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      done_q     <= done_d;
      resp_q     <= resp_d;
      timeout_q  <= timeout_d;
      timer_q    <= timer_d;
    end
  end

  assign done_o       = done_q;
  assign resp_o       = resp_q;
  assign timeout_o    = timeout_q;
  assign busy_o       = (state_q != IDLE);
  assign m_aw_addr_o  = addr_q;
  assign m_aw_prot_o  = 3'b000;
  assign m_aw_valid_o = aw_valid_q;
  assign m_w_data_o   = data_q;
  assign m_w_strb_o   = strb_q;
  assign m_w_valid_o  = w_valid_q;
  assign m_b_ready_o  = b_ready_q;

endmodule

// File: tb/tb_axil_write_arbiter.sv
// Scoreboard bench for axil_write_arbiter: the driver computes expected
// grants, AW/W beats and completions from a round-robin reference model and
// queues them; independent monitors pop and compare when the DUT presents them.
module tb_axil_write_arbiter;

  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [N-1:0]      req_valid_i;
  logic [N*AW-1:0]   req_addr_i;
  logic [N*DW-1:0]   req_data_i;
  logic [N*SW-1:0]   req_strb_i;
  logic [N-1:0]      req_ready_o;
  logic [N-1:0]      done_o;
  logic [1:0]        resp_o;
  logic              timeout_o;
  logic              busy_o;
  logic [AW-1:0]     m_aw_addr_o;
  logic [2:0]        m_aw_prot_o;
  logic              m_aw_valid_o;
  logic              m_aw_ready_i;
  logic [DW-1:0]     m_w_data_o;
  logic [SW-1:0]     m_w_strb_o;
  logic              m_w_valid_o;
  logic              m_w_ready_i;
  logic [1:0]        m_b_resp_i;
  logic              m_b_valid_i;
  logic              m_b_ready_o;

  axil_write_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_strb_i(req_strb_i),
    .req_ready_o(req_ready_o), .done_o(done_o), .resp_o(resp_o),
    .timeout_o(timeout_o), .busy_o(busy_o),
    .m_aw_addr_o(m_aw_addr_o), .m_aw_prot_o(m_aw_prot_o),
    .m_aw_valid_o(m_aw_valid_o), .m_aw_ready_i(m_aw_ready_i),
    .m_w_data_o(m_w_data_o), .m_w_strb_o(m_w_strb_o),
    .m_w_valid_o(m_w_valid_o), .m_w_ready_i(m_w_ready_i),
    .m_b_resp_i(m_b_resp_i), .m_b_valid_i(m_b_valid_i), .m_b_ready_o(m_b_ready_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ptr_m    = 0;

  logic [N-1:0]       exp_grant_q[$];
  logic [AW-1:0]      exp_aw_q[$];
  logic [DW+SW-1:0]   exp_w_q[$];
  logic [N+2:0]       exp_done_q[$];

  wire [N+N+2+1+1+AW+3+1+DW+SW+1+1-1:0] all_outs = {
    req_ready_o, done_o, resp_o, timeout_o, busy_o, m_aw_addr_o, m_aw_prot_o,
    m_aw_valid_o, m_w_data_o, m_w_strb_o, m_w_valid_o, m_b_ready_o};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Reference round robin: first requester at or above ptr, wrapping.
  function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++)
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  function automatic logic [N*AW-1:0] rnd_addr();
    logic [N*AW-1:0] v;
    for (int i = 0; i < N; i++) v[i*AW +: AW] = AW'($urandom);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] rnd_data();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  function automatic logic [N*SW-1:0] rnd_strb();
    logic [N*SW-1:0] v;
    for (int i = 0; i < N; i++) v[i*SW +: SW] = SW'($urandom);
    return v;
  endfunction

  task automatic flush_queues();
    exp_grant_q.delete();
    exp_aw_q.delete();
    exp_w_q.delete();
    exp_done_q.delete();
  endtask

  // Monitors: compare whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (req_ready_o != '0) begin
        if (exp_grant_q.size() == 0) chk("grant_unexpected", req_ready_o, 0);
        else chk("grant_onehot", req_ready_o, exp_grant_q.pop_front());
      end
      if (m_aw_valid_o && m_aw_ready_i) begin
        if (exp_aw_q.size() == 0) chk("aw_unexpected", 1, 0);
        else chk("aw_addr", m_aw_addr_o, exp_aw_q.pop_front());
        chk("aw_prot", m_aw_prot_o, 0);
      end
      if (m_w_valid_o && m_w_ready_i) begin
        if (exp_w_q.size() == 0) chk("w_unexpected", 1, 0);
        else chk("w_data_strb", {m_w_data_o, m_w_strb_o}, exp_w_q.pop_front());
      end
      if (done_o != '0) begin
        if (exp_done_q.size() == 0) chk("done_unexpected", done_o, 0);
        else chk("done_resp_timeout", {done_o, resp_o, timeout_o}, exp_done_q.pop_front());
        chk("done_channel_idle", {m_aw_valid_o, m_w_valid_o, m_b_ready_o}, 0);
      end
    end
  end

  // stall: 0 none, 1 AW never ready, 2 W never ready, 3 B never returned.
  // rst_mid: assert reset once the transaction reaches the response phase.
  task automatic run_txn(input logic [N-1:0] mask, input logic [N*AW-1:0] addrs,
                         input logic [N*DW-1:0] datas, input logic [N*SW-1:0] strbs,
                         input int aw_dly, input int w_dly, input int b_dly,
                         input logic [1:0] bresp, input int stall, input bit rst_mid);
    int g, cyc, done_cyc, hs_cyc, exp_cyc;
    bit to, aw_hs, w_hs, b_hs, done_seen, granted, go_reset;
    logic [N-1:0] oh;
    g  = rr_pick(mask, ptr_m);
    to = (stall != 0);
    oh = '0;
    oh[g] = 1'b1;
    exp_grant_q.push_back(oh);
    if (stall != 1) exp_aw_q.push_back(addrs[g*AW +: AW]);
    if (stall != 2) exp_w_q.push_back({datas[g*DW +: DW], strbs[g*SW +: SW]});
    if (!rst_mid) exp_done_q.push_back({oh, to ? 2'b10 : bresp, to});
    req_addr_i  = addrs;
    req_data_i  = datas;
    req_strb_i  = strbs;
    req_valid_i = mask;

    granted = 0;
    for (int k = 0; k < 8 && !granted; k++) begin
      @(negedge clk);
      if (req_ready_o != '0) granted = 1;
      else begin @(posedge clk); #1; end
    end
    chk("grant_seen", granted, 1);
    if (!granted) begin
      req_valid_i = '0;
      flush_queues();
      return;
    end
    @(posedge clk); #1;
    // Requesters move on; the DUT must have latched the granted request.
    req_valid_i = '0;
    req_addr_i  = rnd_addr();
    req_data_i  = rnd_data();
    req_strb_i  = rnd_strb();

    aw_hs = 0; w_hs = 0; b_hs = 0; done_seen = 0; go_reset = 0;
    hs_cyc = -1; done_cyc = -1; cyc = 0;
    while (cyc < 40 && !done_seen && !go_reset) begin
      m_aw_ready_i = (stall != 1) && !aw_hs && (cyc >= aw_dly);
      m_w_ready_i  = (stall != 2) && !w_hs && (cyc >= w_dly);
      m_b_valid_i  = (stall != 3) && aw_hs && w_hs && !b_hs && (cyc >= hs_cyc + 1 + b_dly);
      m_b_resp_i   = bresp;
      @(negedge clk);
      if (aw_hs) chk("aw_valid_dropped", m_aw_valid_o, 0);
      if (w_hs) chk("w_valid_dropped", m_w_valid_o, 0);
      if (m_aw_valid_o && m_aw_ready_i) aw_hs = 1;
      if (m_w_valid_o && m_w_ready_i) w_hs = 1;
      if (aw_hs && w_hs && hs_cyc < 0) hs_cyc = cyc;
      if (m_b_valid_i && m_b_ready_o) b_hs = 1;
      if (done_o != '0) begin done_seen = 1; done_cyc = cyc; end
      if (rst_mid && m_b_ready_o) go_reset = 1;
      @(posedge clk); #1;
      cyc++;
    end
    m_aw_ready_i = 1'b0;
    m_w_ready_i  = 1'b0;
    m_b_valid_i  = 1'b0;

    if (rst_mid) begin
      chk("reached_resp", go_reset, 1);
      rst_i       = 1'b1;
      req_valid_i = '1;
      #1;
      chk("reset_mid_outputs_zero", all_outs, 0);
      flush_queues();
      repeat (2) @(posedge clk);
      #1;
      req_valid_i = '0;
      rst_i       = 1'b0;
      ptr_m       = 0;
      @(posedge clk); #1;
    end else begin
      chk("done_seen", done_seen, 1);
      if (done_seen) begin
        exp_cyc = to ? (TO - 2) : ((aw_dly > w_dly ? aw_dly : w_dly) + b_dly + 2);
        chk("done_latency", done_cyc, exp_cyc);
        ptr_m = (g + 1) % N;
      end else begin
        flush_queues();
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    req_valid_i = '1;
    req_addr_i = '0; req_data_i = '0; req_strb_i = '0;
    m_aw_ready_i = 1'b0; m_w_ready_i = 1'b0; m_b_valid_i = 1'b0; m_b_resp_i = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_zero", all_outs, 0);
    req_valid_i = '0;
    rst_i = 1'b0;
    @(posedge clk); #1;

    // Requester 0 alone, best-case slave.
    run_txn(3'b001, {N{4'h0}}, {N{32'h10101010}}, {N{4'hF}}, 0, 0, 0, 2'b00, 0, 0);
    // Reset while waiting for B on requester 1; pointer must return to 0.
    run_txn(3'b010, {N{4'hC}}, {N{32'h40404040}}, {N{4'hF}}, 0, 0, 0, 2'b00, 3, 1);
    // Two requesters contending: expect strict alternation starting at 0.
    for (int i = 0; i < 4; i++)
      run_txn(3'b011, rnd_addr(), rnd_data(), rnd_strb(), 0, 0, 0, 2'b00, 0, 0);
    // W ready delayed three cycles after AW.
    run_txn(3'b001, {N{4'h4}}, {N{32'h20202020}}, {N{4'hF}}, 0, 3, 0, 2'b00, 0, 0);
    // Slave error response passes through without a timeout.
    run_txn(3'b100, {N{4'h8}}, {N{32'h30303030}}, {N{4'hF}}, 0, 0, 0, 2'b10, 0, 0);
    // AW never accepted: timeout abort, then service continues.
    run_txn(3'b010, rnd_addr(), rnd_data(), rnd_strb(), 0, 0, 0, 2'b00, 1, 0);
    run_txn(3'b111, rnd_addr(), rnd_data(), rnd_strb(), 0, 0, 0, 2'b01, 0, 0);

    for (int i = 0; i < 40; i++) begin
      int st;
      st = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_txn(N'($urandom_range(1, (1 << N) - 1)), rnd_addr(), rnd_data(), rnd_strb(),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), 2'($urandom), st, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queues_drained",
        exp_grant_q.size() + exp_aw_q.size() + exp_w_q.size() + exp_done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
